// File: rtl/inst_cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES  = 4;
  localparam int CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch port and line-fill port of the instruction cache as one bundle.
interface inst_cache_if #(
  parameter int WORD_SIZE  = inst_cache_pkg::WORD_SIZE,
  parameter int LINE_WORDS = inst_cache_pkg::LINE_WORDS
);

  // Fetch: the CPU holds readM1/address1 and a word transfers in any cycle with
  // readM1=1 and i_ready=1. Fill: mem_req/mem_address hold steady until the
  // single-cycle mem_ready pulse; mem_line is sampled only in that cycle.
  logic                            readM1;
  logic [WORD_SIZE-1:0]            address1;
  logic [WORD_SIZE-1:0]            data1;
  logic                            i_ready;
  logic                            mem_req;
  logic [WORD_SIZE-1:0]            mem_address;
  logic                            mem_ready;
  logic [WORD_SIZE*LINE_WORDS-1:0] mem_line;

  modport slave (
    input  readM1, address1, mem_ready, mem_line,
    output data1, i_ready, mem_req, mem_address
  );

  modport master (
    output readM1, address1, mem_ready, mem_line,
    input  data1, i_ready, mem_req, mem_address
  );

endinterface

// File: rtl/inst_cache_line_array.sv
// Valid/tag/data storage: combinational read, synchronous line write, async valid clear.
module cache_line_array #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter int IDX_W      = 2,
  parameter int TAG_W      = 12
) (
  input  logic                            Clk,
  input  logic                            Reset_N,
  input  logic [IDX_W-1:0]                rd_index,
  output logic                            rd_valid,
  output logic [TAG_W-1:0]                rd_tag,
  output logic [WORD_SIZE*LINE_WORDS-1:0] rd_line,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_index,
  input  logic [TAG_W-1:0]                wr_tag,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] wr_line
);
  import inst_cache_pkg::*;

  logic [NUM_LINES-1:0]            valid_q;
  logic [TAG_W-1:0]                tag_arr  [NUM_LINES];
  logic [WORD_SIZE*LINE_WORDS-1:0] data_arr [NUM_LINES];

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the matching valid bit is set.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      tag_arr[wr_index]  <= wr_tag;
      data_arr[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_arr[rd_index];
  assign rd_line  = data_arr[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stalls fetch while a line fills.
module inst_cache #(
  parameter int WORD_SIZE  = inst_cache_pkg::WORD_SIZE,
  parameter int LINE_WORDS = inst_cache_pkg::LINE_WORDS,
  parameter int NUM_LINES  = inst_cache_pkg::NUM_LINES,
  parameter int CNT_WIDTH  = inst_cache_pkg::CNT_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  inst_cache_if.slave           bus,
  output logic [CNT_WIDTH-1:0]  num_hits,
  output logic [CNT_WIDTH-1:0]  num_misses,
  output inst_cache_pkg::state_t state_dbg
);
  import inst_cache_pkg::*;

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  logic [OFF_W-1:0]     req_offset;
  logic [IDX_W-1:0]     req_index;
  logic [TAG_W-1:0]     req_tag;

  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_W-1:0]    rd_line;

  state_t               state_q, state_d;
  logic                 hit;
  logic                 miss_start;
  logic                 fill_done;
  logic                 lookup_hit;

  logic                 mem_req_q;
  logic [WORD_SIZE-1:0] mem_address_q;
  logic [CNT_WIDTH-1:0] num_hits_q;
  logic [CNT_WIDTH-1:0] num_misses_q;

  assign req_offset = bus.address1[OFF_W-1:0];
  assign req_index  = bus.address1[OFF_W +: IDX_W];
  assign req_tag    = bus.address1[WORD_SIZE-1 -: TAG_W];

  // The latched fill address carries the miss tag and index, so the fill
  // lands in the right line even if address1 moves during FILL.
  cache_line_array #(
    .WORD_SIZE  (WORD_SIZE),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_lines (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill_done),
    .wr_index (mem_address_q[OFF_W +: IDX_W]),
    .wr_tag   (mem_address_q[WORD_SIZE-1 -: TAG_W]),
    .wr_line  (bus.mem_line)
  );

  assign lookup_hit = rd_valid && (rd_tag == req_tag);

  always_comb begin
    state_d    = state_q;
    hit        = 1'b0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.readM1) begin
          if (lookup_hit) begin
            hit = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        if (bus.mem_ready) begin
          fill_done = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_address_q <= '0;
      num_hits_q    <= '0;
      num_misses_q  <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        mem_req_q     <= 1'b1;
        mem_address_q <= {req_tag, req_index, {OFF_W{1'b0}}};
        num_misses_q  <= num_misses_q + 1'b1;
      end else if (fill_done) begin
        mem_req_q <= 1'b0;
      end
      if (hit) begin
        num_hits_q <= num_hits_q + 1'b1;
      end
    end
  end

  assign bus.i_ready     = hit;
  assign bus.data1       = hit ? rd_line[req_offset*WORD_SIZE +: WORD_SIZE] : '0;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_address = mem_address_q;
  assign num_hits        = num_hits_q;
  assign num_misses      = num_misses_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_inst_cache.sv
// Randomised scoreboard bench for inst_cache against a line-address reference model.
module tb_inst_cache;
  import inst_cache_pkg::*;

  localparam int TB_CNT_W = 6;

  logic Clk = 1'b0;
  logic Reset_N = 1'b0;
  always #5 Clk = ~Clk;

  inst_cache_if bus ();
  logic [TB_CNT_W-1:0] num_hits;
  logic [TB_CNT_W-1:0] num_misses;
  state_t              state_dbg;

  inst_cache #(.CNT_WIDTH(TB_CNT_W)) dut (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .bus        (bus),
    .num_hits   (num_hits),
    .num_misses (num_misses),
    .state_dbg  (state_dbg)
  );

  // scoreboard state
  logic [15:0] exp_q[$];
  logic [15:0] exp_addr_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // reference model: which memory line sits in each cache slot
  bit          slot_v [4];
  logic [13:0] slot_line [4];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;
  int unsigned exp_fills = 0;
  int unsigned fills_done = 0;

  logic [15:0] salt;
  int          force_lat = 0;
  int          last_lat = 0;
  bit          hold_mem = 1'b0;
  int          stray_cnt = 0;
  int          stray_done = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  function automatic logic [63:0] build_line(input logic [15:0] a);
    logic [63:0] l;
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      w = {a[15:2], 2'(k)};
      l[16*k +: 16] = mem_word(w);
    end
    return l;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) slot_v[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_num_hits"}, 32'(num_hits), exp_hits % (1 << TB_CNT_W));
    check({tag, "_num_misses"}, 32'(num_misses), exp_misses % (1 << TB_CNT_W));
  endtask

  // Monitor: every accepted fetch word is popped and compared.
  always @(negedge Clk) begin
    if (mon_en && Reset_N && bus.i_ready) begin
      if (!bus.readM1) check("i_ready_without_readM1", 32'(bus.i_ready), 32'd0);
      else if (exp_q.size() == 0) check("unexpected_i_ready", 32'(bus.i_ready), 32'd0);
      else check("data1", 32'(bus.data1), 32'(exp_q.pop_front()));
    end
  end

  // Memory responder: answers each fill request after a random latency.
  initial begin
    int          lat;
    logic [15:0] addr_seen;
    bus.mem_ready = 1'b0;
    bus.mem_line  = '0;
    forever begin
      @(negedge Clk);
      if (stray_cnt != stray_done) begin
        bus.mem_line  = 64'hDEAD_BEEF_0BAD_F00D;
        bus.mem_ready = 1'b1;
        @(posedge Clk); #1;
        bus.mem_ready = 1'b0;
        stray_done++;
      end else if (Reset_N && bus.mem_req && !hold_mem) begin
        lat = (force_lat != 0) ? force_lat : $urandom_range(1, 5);
        last_lat = lat;
        addr_seen = bus.mem_address;
        if (exp_addr_q.size() == 0) check("spurious_mem_req", 32'(bus.mem_req), 32'd0);
        else check("mem_address", 32'(bus.mem_address), 32'(exp_addr_q.pop_front()));
        for (int i = 1; i < lat; i++) begin
          @(negedge Clk);
          check("mem_req_held", 32'(bus.mem_req), 32'd1);
          check("mem_address_stable", 32'(bus.mem_address), 32'(addr_seen));
        end
        bus.mem_line  = build_line(addr_seen);
        bus.mem_ready = 1'b1;
        @(posedge Clk); #1;
        bus.mem_ready = 1'b0;
        fills_done++;
        check("mem_req_drop", 32'(bus.mem_req), 32'd0);
      end
    end
  end

  // Issue one fetch and hold it until accepted. Optionally, during the fill,
  // move to another word of the same line (alt) and/or drop readM1 for a cycle.
  task automatic fetch(input logic [15:0] a, input bit alt_en, input logic [15:0] alt, input bit drop);
    int  slot;
    bit  hit;
    bit  done;
    int  cyc;
    slot = int'(a[3:2]);
    hit  = slot_v[slot] && (slot_line[slot] == a[15:2]);
    exp_q.push_back(mem_word((alt_en && !hit) ? alt : a));
    exp_hits++;
    if (!hit) begin
      exp_misses++;
      exp_fills++;
      exp_addr_q.push_back({a[15:2], 2'b00});
      slot_v[slot]    = 1'b1;
      slot_line[slot] = a[15:2];
    end
    bus.readM1   = 1'b1;
    bus.address1 = a;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc <= 40) begin
      @(negedge Clk);
      if (bus.i_ready && bus.readM1) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (alt_en && cyc == 1) begin
          @(posedge Clk); #1;
          bus.address1 = alt;
          bus.readM1   = !drop;
        end else if (alt_en && cyc == 2) begin
          @(posedge Clk); #1;
          bus.readM1 = 1'b1;
        end
      end
    end
    if (!done) begin
      check("fetch_timeout", 32'(bus.i_ready), 32'd1);
      void'(exp_q.pop_back());
    end else if (hit) begin
      check("hit_latency", 32'(cyc), 32'd0);
      check("mem_req_on_hit", 32'(bus.mem_req), 32'd0);
    end else begin
      check("miss_latency", 32'(cyc), 32'(last_lat + 2));
    end
    @(posedge Clk); #1;
    check_counters("fetch");
  endtask

  task automatic idle_cycles(input int n);
    bus.readM1   = 1'b0;
    bus.address1 = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check("idle_i_ready", 32'(bus.i_ready), 32'd0);
      check("idle_data1", 32'(bus.data1), 32'd0);
      check("idle_mem_req", 32'(bus.mem_req), 32'd0);
      @(posedge Clk); #1;
    end
    check_counters("idle");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    logic [1:0]  r2;
    salt = 16'($urandom);
    bus.readM1   = 1'b0;
    bus.address1 = '0;
    model_reset();

    // reset state, including a fetch request presented while still in reset
    repeat (2) @(negedge Clk);
    bus.readM1   = 1'b1;
    bus.address1 = 16'h0005;
    @(negedge Clk);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_i_ready", 32'(bus.i_ready), 32'd0);
    check("rst_data1", 32'(bus.data1), 32'd0);
    check_counters("rst");
    bus.readM1 = 1'b0;
    Reset_N    = 1'b1;
    @(posedge Clk); #1;
    mon_en = 1'b1;

    // cold miss with a 3-cycle memory, then spatial hits across the line
    force_lat = 3;
    fetch(16'h0005, 1'b0, 16'h0, 1'b0);
    force_lat = 0;
    for (int i = 4; i < 8; i++) fetch(16'(i), 1'b0, 16'h0, 1'b0);

    // conflict misses on index 1
    fetch(16'h0014, 1'b0, 16'h0, 1'b0);
    fetch(16'h0004, 1'b0, 16'h0, 1'b0);
    fetch(16'h0015, 1'b0, 16'h0, 1'b0);

    // address change and readM1 drop during a fill
    fetch(16'h0020, 1'b1, 16'h0021, 1'b0);
    fetch(16'h0022, 1'b0, 16'h0, 1'b0);
    fetch(16'h0033, 1'b1, 16'h0030, 1'b1);

    // idle with a stray mem_ready pulse
    stray_cnt++;
    idle_cycles(10);
    check("stray_state", 32'(state_dbg), 32'(IDLE));
    fetch(16'h0021, 1'b0, 16'h0, 1'b0);

    // reset in the middle of a fill, then a late mem_ready
    fetch(16'h0008, 1'b0, 16'h0, 1'b0);
    hold_mem     = 1'b1;
    bus.readM1   = 1'b1;
    bus.address1 = 16'h0044;
    @(negedge Clk);
    @(posedge Clk); #1;
    check("midfill_state", 32'(state_dbg), 32'(FILL));
    check("midfill_mem_req", 32'(bus.mem_req), 32'd1);
    bus.readM1 = 1'b0;
    @(negedge Clk);
    Reset_N = 1'b0;
    #1;
    check("rst_fill_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_fill_state", 32'(state_dbg), 32'(IDLE));
    model_reset();
    @(negedge Clk);
    Reset_N = 1'b1;
    stray_cnt++;
    idle_cycles(4);
    hold_mem = 1'b0;
    check("late_ready_state", 32'(state_dbg), 32'(IDLE));
    fetch(16'h0044, 1'b0, 16'h0, 1'b0);
    fetch(16'h0008, 1'b0, 16'h0, 1'b0);

    // randomised traffic; 6-bit counters wrap during this phase
    for (int n = 0; n < 300; n++) begin
      a  = ($urandom_range(0, 9) < 7) ? 16'($urandom_range(0, 63)) : 16'($urandom);
      r2 = 2'($urandom_range(0, 3));
      fetch(a, ($urandom_range(0, 4) == 0), {a[15:2], r2}, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) idle_cycles($urandom_range(1, 3));
    end

    idle_cycles(3);
    check("fills_done", 32'(fills_done), 32'(exp_fills));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_addr_q_drained", 32'(exp_addr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
